// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port unified memory between fetch (IF) and load/store (LS).
// LS wins ties until STARVE_MAX consecutive LS grants have gone by with IF waiting; then IF wins.
// One access at a time, request held until ack; per-requester valid/stall for the hazard logic.
// Optional feature macro: ARB_TIMEOUT_EN (abort a BUSY access after TIMEOUT cycles, sticky bus_err).
// DPW matches the data/address width of rv32i_pkg.
module mem_port_arbiter #(
  parameter int unsigned DPW        = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           if_req,
  input  logic [DPW-1:0] if_addr,
  output logic [DPW-1:0] if_rdata,
  output logic           if_valid,
  input  logic           ls_req,
  input  logic           ls_we,
  input  logic [DPW-1:0] ls_addr,
  input  logic [DPW-1:0] ls_wdata,
  input  logic [3:0]     ls_be,
  output logic [DPW-1:0] ls_rdata,
  output logic           ls_valid,
  output logic           if_stall,
  output logic           ls_stall,
  output logic           mem_req,
  output logic           mem_we,
  output logic [DPW-1:0] mem_addr,
  output logic [DPW-1:0] mem_wdata,
  output logic [3:0]     mem_be,
  input  logic           mem_ack,
  input  logic [DPW-1:0] mem_rdata,
  output logic           bus_err
);

  typedef enum logic [1:0] {StIdle, StBusyIf, StBusyLs} state_e;

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  state_e         state_q, state_d;
  logic [3:0]     streak_q, streak_d;
  logic [DPW-1:0] addr_q, addr_d;
  logic [DPW-1:0] wdata_q, wdata_d;
  logic           we_q, we_d;
  logic [3:0]     be_q, be_d;
  logic           abort;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  logic [7:0] wait_q, wait_d;
  logic       bus_err_q, bus_err_d;

  // Wait counter restarts in IDLE (i.e. at every grant); abort on the TIMEOUT-th silent BUSY cycle.
  always_comb begin
    wait_d    = (state_q == StIdle) ? 8'd0 : wait_q + 8'd1;
    abort     = (state_q != StIdle) && !mem_ack && (wait_q == TimeoutLast);
    bus_err_d = bus_err_q | abort;
  end

  // Timeout state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q    <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign abort          = 1'b0;
  assign bus_err        = 1'b0;
`endif

  // Arbitration, grant capture and completion.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    be_d     = be_q;
    unique case (state_q)
      StIdle: begin
        if (!if_req) streak_d = 4'd0;
        if (ls_req && (!if_req || (streak_q < StarveMax))) begin
          state_d = StBusyLs;
          addr_d  = ls_addr;
          wdata_d = ls_wdata;
          we_d    = ls_we;
          be_d    = ls_be;
          if (if_req) streak_d = streak_q + 4'd1;
        end else if (if_req) begin
          state_d  = StBusyIf;
          addr_d   = if_addr;
          wdata_d  = '0;
          we_d     = 1'b0;
          be_d     = 4'hF;
          streak_d = 4'd0;
        end
      end
      StBusyIf, StBusyLs: begin
        if (mem_ack || abort) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and captured-request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      streak_q <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      be_q     <= 4'h0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      be_q     <= be_d;
    end
  end

  // Outputs: bus strobes gated to zero when idle; read data zero unless a real ack completes.
  always_comb begin
    mem_req   = (state_q != StIdle);
    mem_we    = we_q & mem_req;
    mem_be    = mem_req ? be_q : 4'h0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_valid  = (state_q == StBusyIf) && (mem_ack || abort);
    ls_valid  = (state_q == StBusyLs) && (mem_ack || abort);
    if_rdata  = (if_valid && mem_ack) ? mem_rdata : '0;
    ls_rdata  = (ls_valid && mem_ack) ? mem_rdata : '0;
    if_stall  = if_req & ~if_valid;
    ls_stall  = ls_req & ~ls_valid;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected grants/responses,
// a negedge monitor pops and compares whenever the DUT starts an access or raises a valid.
module tb_mem_port_arbiter;

  typedef struct {
    bit          is_ls;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } grant_t;

  typedef struct {
    bit          is_ls;
    bit          chk;
    logic [31:0] rdata;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0, mem_ack = 1'b0;
  logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0, mem_rdata = '0;
  logic [3:0]  ls_be = 4'h0;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic        if_valid, ls_valid, if_stall, ls_stall, mem_req, mem_we, bus_err;
  logic [3:0]  mem_be;

  int checks = 0;
  int failures = 0;
  int resp_cnt = 0;
  bit ack_en = 1'b0;
  int ack_delay = 0;
  grant_t grant_q[$];
  resp_t  resp_q[$];

  mem_port_arbiter #(.DPW(32), .STARVE_MAX(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
    .ls_rdata(ls_rdata), .ls_valid(ls_valid), .if_stall(if_stall), .ls_stall(ls_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0050_0093 : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_grant(input bit is_ls, input logic [31:0] a, input logic we,
                            input logic [31:0] wd, input logic [3:0] be);
    grant_t g;
    g.is_ls = is_ls; g.addr = a; g.we = we; g.wdata = wd; g.be = be;
    grant_q.push_back(g);
  endtask

  task automatic push_resp(input bit is_ls, input bit chk, input logic [31:0] rd);
    resp_t r;
    r.is_ls = is_ls; r.chk = chk; r.rdata = rd;
    resp_q.push_back(r);
  endtask

  // Wait (bounded) until the monitor has seen `target` responses in total.
  task automatic wait_resp(input int target, input int budget, input string name);
    int n = 0;
    while (resp_cnt < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check({name, "_done"}, 32'(resp_cnt >= target), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Memory responder: ack `ack_delay` cycles after mem_req is first seen high.
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (ack_en) begin
        mem_ack = 1'b0;
        if (mem_req) begin
          if (cnt == ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_model(mem_addr);
            cnt       = 0;
          end else cnt++;
        end else cnt = 0;
      end else cnt = 0;
    end
  end

  // Monitor: compare every grant and every valid against the scoreboard queues.
  initial begin
    logic  req_prev = 1'b0;
    grant_t g;
    resp_t  r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_req && !req_prev) begin
          if (grant_q.size() == 0) check("unexpected_grant", 32'(mem_addr), 32'hFFFF_FFFF);
          else begin
            g = grant_q.pop_front();
            check("grant_addr", mem_addr, g.addr);
            check("grant_we", 32'(mem_we), 32'(g.we));
            check("grant_be", 32'(mem_be), 32'(g.be));
            if (g.is_ls) check("grant_wdata", mem_wdata, g.wdata);
          end
        end
        if (if_valid || ls_valid) begin
          check("valid_exclusive", 32'(if_valid & ls_valid), 32'd0);
          if (resp_q.size() == 0) check("unexpected_valid", 32'({if_valid, ls_valid}), 32'd0);
          else begin
            r = resp_q.pop_front();
            check("resp_owner_ls", 32'(ls_valid), 32'(r.is_ls));
            if (r.chk) check("resp_rdata", r.is_ls ? ls_rdata : if_rdata, r.rdata);
          end
          resp_cnt++;
        end
      end
      req_prev = mem_req;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int n;
    logic vl, vi;

    // Reset values
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_valids", 32'({if_valid, ls_valid}), 32'd0);
    check("rst_rdata", if_rdata | ls_rdata, 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);

    // Single fetch, ack one cycle after mem_req
    ack_en = 1'b1; ack_delay = 1;
    push_grant(1'b0, 32'h100, 1'b0, 32'h0, 4'hF);
    push_resp(1'b0, 1'b1, 32'h0050_0093);
    @(posedge clk); #1 if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    check("fetch_latency_req_low", 32'(mem_req), 32'd0);
    check("fetch_stall_idle", 32'(if_stall), 32'd1);
    @(negedge clk);
    check("fetch_stall_busy", 32'(if_stall), 32'd1);
    wait_resp(1, 20, "fetch");
    check("fetch_stall_on_valid", 32'(if_stall), 32'd0);
    @(posedge clk); #1 if_req = 1'b0;
    @(negedge clk);
    check("fetch_valid_one_cycle", 32'(if_valid), 32'd0);
    check("fetch_idle_req", 32'(mem_req), 32'd0);

    // Store
    ack_delay = 0;
    push_grant(1'b1, 32'h2004, 1'b1, 32'hDEAD_BEEF, 4'h3);
    push_resp(1'b1, 1'b0, 32'h0);
    @(posedge clk); #1 ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h2004;
    ls_wdata = 32'hDEAD_BEEF; ls_be = 4'h3;
    @(negedge clk);
    check("store_stall_idle", 32'(ls_stall), 32'd1);
    wait_resp(2, 20, "store");
    @(posedge clk); #1 ls_req = 1'b0; ls_we = 1'b0;
    @(negedge clk);
    check("store_idle_we", 32'(mem_we), 32'd0);
    check("store_idle_be", 32'(mem_be), 32'd0);
    check("store_idle_req", 32'(mem_req), 32'd0);

    // Both requests held: LS x4, IF, LS x4, IF, LS x2
    for (int i = 0; i < 12; i++) begin
      logic [31:0] la, ia;
      la = 32'h3000 + 32'(4 * (i - i / 5));
      ia = 32'h0000 + 32'(4 * (i / 5));
      if (i % 5 == 4) begin
        push_grant(1'b0, ia, 1'b0, 32'h0, 4'hF);
        push_resp(1'b0, 1'b1, mem_model(ia));
      end else begin
        push_grant(1'b1, la, 1'b0, 32'h0, 4'hF);
        push_resp(1'b1, 1'b1, mem_model(la));
      end
    end
    @(posedge clk); #1;
    ls_we = 1'b0; ls_be = 4'hF; ls_wdata = 32'h0; ls_addr = 32'h3000; if_addr = 32'h0;
    ls_req = 1'b1; if_req = 1'b1;
    got = 0; n = 0;
    while (got < 12 && n < 300) begin
      @(negedge clk);
      vl = ls_valid; vi = if_valid;
      if (vl || vi) got++;
      @(posedge clk); #1;
      n++;
      if (got == 12) begin
        ls_req = 1'b0; if_req = 1'b0;
      end else begin
        if (vl) ls_addr = ls_addr + 32'd4;
        if (vi) if_addr = if_addr + 32'd4;
      end
    end
    ls_req = 1'b0; if_req = 1'b0;
    check("seq_12_grants", 32'(got), 32'd12);
    repeat (2) @(negedge clk);
    check("seq_queue_empty", 32'(grant_q.size() + resp_q.size()), 32'd0);

    // Reset mid-access, then stray ack
    ack_en = 1'b0; mem_ack = 1'b0;
    push_grant(1'b1, 32'h4000, 1'b0, 32'h0, 4'hF);
    @(posedge clk); #1 ls_req = 1'b1; ls_addr = 32'h4000;
    n = 0;
    while (!mem_req && n < 10) begin @(posedge clk); #1; n++; end
    check("rstmid_busy", 32'(mem_req), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; ls_req = 1'b0;
    @(negedge clk);
    check("rstmid_req_dropped", 32'(mem_req), 32'd0);
    check("rstmid_no_valid", 32'(ls_valid), 32'd0);
    @(posedge clk); #1 mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    check("stray_ack_no_valid", 32'({if_valid, ls_valid}), 32'd0);
    check("stray_ack_rdata", if_rdata | ls_rdata, 32'd0);
    @(posedge clk); #1 mem_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_idle", 32'(mem_req), 32'd0);

    // No ack: timeout abort when enabled, indefinite wait otherwise
    push_grant(1'b1, 32'h5000, 1'b0, 32'h0, 4'hF);
`ifdef ARB_TIMEOUT_EN
    push_resp(1'b1, 1'b1, 32'h0);
    @(posedge clk); #1 ls_req = 1'b1; ls_addr = 32'h5000;
    wait_resp(resp_cnt + 1, 30, "timeout");
    @(posedge clk); #1 ls_req = 1'b0;
    repeat (3) @(negedge clk);
    check("timeout_bus_err_sticky", 32'(bus_err), 32'd1);
    check("timeout_req_dropped", 32'(mem_req), 32'd0);
    do_reset();
    @(negedge clk);
    check("timeout_err_cleared", 32'(bus_err), 32'd0);
`else
    @(posedge clk); #1 ls_req = 1'b1; ls_addr = 32'h5000;
    repeat (110) @(posedge clk);
    @(negedge clk);
    check("hang_still_busy", 32'(mem_req), 32'd1);
    check("hang_stall", 32'(ls_stall), 32'd1);
    check("hang_bus_err", 32'(bus_err), 32'd0);
    #1 ls_req = 1'b0;
    do_reset();
    @(negedge clk);
    check("hang_reset_idle", 32'(mem_req), 32'd0);
`endif

    repeat (2) @(negedge clk);
    check("final_queues_empty", 32'(grant_q.size() + resp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
